// File: rtl/td4_loader_if.sv
// Host byte stream and program-memory write port of the TD4 program loader.
interface td4_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/td4_loader.sv
// TD4 program loader: header, 16 program bytes, checksum; holds the CPU in
// reset while a frame is in flight and reports the outcome with sticky flags.
module td4_loader #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    td4_loader_if.slave bus,
    output logic        cpu_hold,
    output logic        load_ok,
    output logic        load_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        SUM  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           stateNext_s;
    logic [3:0]       index_r;
    logic [3:0]       indexNext_s;
    logic [7:0]       sum_r;
    logic [7:0]       sumNext_s;
    logic [CNT_W-1:0] idleCnt_r;
    logic [CNT_W-1:0] idleNext_s;
    logic             inReady_r;
    logic             wrEn_r;
    logic             wrEnNext_s;
    logic [3:0]       wrAddr_r;
    logic [3:0]       wrAddrNext_s;
    logic [7:0]       wrData_r;
    logic [7:0]       wrDataNext_s;
    logic             cpuHold_r;
    logic             holdNext_s;
    logic             loadOk_r;
    logic             okNext_s;
    logic             loadErr_r;
    logic             errNext_s;
    logic             accept_s;
    logic             timeout_s;

    function automatic logic [7:0] sumAdd(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    assign accept_s  = bus.in_valid & inReady_r;
    // An accept on the expiry cycle takes priority over the timeout.
    assign timeout_s = (~accept_s) & (idleCnt_r == CNT_LAST);

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        stateNext_s  = state_r;
        indexNext_s  = index_r;
        sumNext_s    = sum_r;
        idleNext_s   = idleCnt_r;
        wrEnNext_s   = 1'b0;
        wrAddrNext_s = wrAddr_r;
        wrDataNext_s = wrData_r;
        holdNext_s   = cpuHold_r;
        okNext_s     = loadOk_r;
        errNext_s    = loadErr_r;
        case (state_r)
            IDLE: begin
                idleNext_s = CNT_ZERO;
                if (accept_s && (bus.in_data == HEADER)) begin
                    stateNext_s = DATA;
                    indexNext_s = 4'd0;
                    sumNext_s   = 8'd0;
                    holdNext_s  = 1'b1;
                    okNext_s    = 1'b0;
                    errNext_s   = 1'b0;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            DATA: begin
                if (accept_s) begin
                    idleNext_s   = CNT_ZERO;
                    wrEnNext_s   = 1'b1;
                    wrAddrNext_s = index_r;
                    wrDataNext_s = bus.in_data;
                    sumNext_s    = sumAdd(sum_r, bus.in_data);
                    indexNext_s  = index_r + 4'd1;
                    if (index_r == 4'd15) begin
                        stateNext_s = SUM;
                    end else begin
                        stateNext_s = DATA;
                    end
                end else if (timeout_s) begin
                    idleNext_s  = CNT_ZERO;
                    errNext_s   = 1'b1;
                    holdNext_s  = 1'b1;
                    stateNext_s = IDLE;
                end else begin
                    idleNext_s = idleCnt_r + CNT_ONE;
                end
            end
            SUM: begin
                if (accept_s) begin
                    idleNext_s  = CNT_ZERO;
                    stateNext_s = IDLE;
                    if (bus.in_data == sum_r) begin
                        okNext_s   = 1'b1;
                        holdNext_s = 1'b0;
                    end else begin
                        errNext_s  = 1'b1;
                        holdNext_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    idleNext_s  = CNT_ZERO;
                    errNext_s   = 1'b1;
                    holdNext_s  = 1'b1;
                    stateNext_s = IDLE;
                end else begin
                    idleNext_s = idleCnt_r + CNT_ONE;
                end
            end
            default: begin
                stateNext_s = IDLE;
                idleNext_s  = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            index_r   <= 4'd0;
            sum_r     <= 8'd0;
            idleCnt_r <= CNT_ZERO;
            inReady_r <= 1'b0;
            wrEn_r    <= 1'b0;
            wrAddr_r  <= 4'd0;
            wrData_r  <= 8'd0;
            cpuHold_r <= 1'b0;
            loadOk_r  <= 1'b0;
            loadErr_r <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            index_r   <= indexNext_s;
            sum_r     <= sumNext_s;
            idleCnt_r <= idleNext_s;
            inReady_r <= 1'b1;
            wrEn_r    <= wrEnNext_s;
            wrAddr_r  <= wrAddrNext_s;
            wrData_r  <= wrDataNext_s;
            cpuHold_r <= holdNext_s;
            loadOk_r  <= okNext_s;
            loadErr_r <= errNext_s;
        end
    end

    assign bus.in_ready = inReady_r;
    assign bus.wr_en    = wrEn_r;
    assign bus.wr_addr  = wrAddr_r;
    assign bus.wr_data  = wrData_r;
    assign cpu_hold     = cpuHold_r;
    assign load_ok      = loadOk_r;
    assign load_err     = loadErr_r;

endmodule

// File: tb/tb_td4_loader.sv
// Bench for td4_loader: directed frames plus randomized frames checked against
// a frame-level reference model of memory contents, write order and flags.
module tb_td4_loader;
    localparam int         TO  = 8;
    localparam logic [7:0] HDR = 8'hA5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic cpu_hold;
    logic load_ok;
    logic load_err;

    always #5 clock = ~clock;

    td4_loader_if bus();

    td4_loader #(.HEADER(HDR), .TIMEOUT(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .load_ok  (load_ok),
        .load_err (load_err)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  mem[16];
    logic [11:0] wrLog[$];
    logic [7:0]  fd[16];
    logic [7:0]  expMem[16];
    logic        expOk;
    logic        expErr;
    logic        expHold;
    int          expWrites;
    int          wrBase;

    // Program memory plus a log of every write strobe.
    always @(posedge clock) begin
        if (bus.wr_en === 1'b1) begin
            mem[bus.wr_addr] <= bus.wr_data;
            wrLog.push_back({bus.wr_addr, bus.wr_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            bus.in_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic chkFlags(input string tag, input logic h, input logic o, input logic e);
        chk({tag, ".hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, ".ok"},   32'(load_ok),  32'(o));
        chk({tag, ".err"},  32'(load_err), 32'(e));
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, ".ready"}, 32'(bus.in_ready), 32'(1'b0));
        chk({tag, ".wren"},  32'(bus.wr_en),    32'(1'b0));
        chk({tag, ".waddr"}, 32'(bus.wr_addr),  32'(4'd0));
        chk({tag, ".wdata"}, 32'(bus.wr_data),  32'(8'd0));
        chkFlags(tag, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] refSum();
        int s = 0;
        foreach (fd[i]) s += int'(fd[i]);
        return 8'(s % 256);
    endfunction

    // Frame outcome from the loader's rules; abortAt <= 16 means the host
    // stopped sending after abortAt data bytes and the frame timed out.
    task automatic modelFrame(input int abortAt, input logic [7:0] csum);
        int n = (abortAt < 16) ? abortAt : 16;
        for (int i = 0; i < n; i++) expMem[i] = fd[i];
        expWrites = n;
        if (abortAt <= 16) begin
            expOk = 1'b0; expErr = 1'b1; expHold = 1'b1;
        end else if (csum == refSum()) begin
            expOk = 1'b1; expErr = 1'b0; expHold = 1'b0;
        end else begin
            expOk = 1'b0; expErr = 1'b1; expHold = 1'b1;
        end
    endtask

    task automatic checkFrame(input string tag);
        chk({tag, ".writes"}, 32'(wrLog.size() - wrBase), 32'(expWrites));
        for (int i = 0; i < expWrites && (wrBase + i) < wrLog.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), 32'(wrLog[wrBase + i][11:8]), 32'(i));
            chk($sformatf("%s.data%0d", tag, i), 32'(wrLog[wrBase + i][7:0]), 32'(fd[i]));
        end
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s.mem%0d", tag, i), 32'(mem[i]), 32'(expMem[i]));
        chkFlags(tag, expHold, expOk, expErr);
    endtask

    task automatic runFrame(input string tag, input bit gaps, input int abortAt, input logic [7:0] csum);
        int g;
        wrBase = wrLog.size();
        sendByte(HDR);
        for (int i = 0; i < 17; i++) begin
            if (i == abortAt) begin
                idle(TO + int'($urandom_range(3, 0)));
                break;
            end
            if (gaps) begin
                g = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : 0;
                idle(g);
            end
            sendByte((i < 16) ? fd[i] : csum);
        end
        modelFrame(abortAt, csum);
        checkFrame(tag);
    endtask

    initial begin
        logic [7:0] junk;
        int         nJunk;
        int         abortAt;
        logic [7:0] csum;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        tick();
        tick();
        chkResetOutputs("reset");
        reset = 1'b1;
        chk("ready_before_edge", 32'(bus.in_ready), 32'(1'b0));
        tick();
        chk("ready_after_edge", 32'(bus.in_ready), 32'(1'b1));

        // Frame 00..0F with checksum 78, back-to-back.
        for (int i = 0; i < 16; i++) fd[i] = 8'(i);
        wrBase = wrLog.size();
        sendByte(HDR);
        chkFlags("hdr", 1'b1, 1'b0, 1'b0);
        chk("hdr.wren", 32'(bus.wr_en), 32'(1'b0));
        for (int i = 0; i < 16; i++) begin
            sendByte(fd[i]);
            chk($sformatf("seq.wren%0d", i),  32'(bus.wr_en),   32'(1'b1));
            chk($sformatf("seq.waddr%0d", i), 32'(bus.wr_addr), 32'(i));
            chk($sformatf("seq.wdata%0d", i), 32'(bus.wr_data), 32'(fd[i]));
            chk($sformatf("seq.hold%0d", i),  32'(cpu_hold),    32'(1'b1));
        end
        sendByte(8'h78);
        chk("seq.wren_sum", 32'(bus.wr_en), 32'(1'b0));
        modelFrame(99, 8'h78);
        checkFrame("frame_good");
        chk("frame_good.ok_const", 32'(load_ok), 32'(1'b1));

        // Bad checksum, then recovery.
        runFrame("frame_badsum", 1'b0, 99, 8'h79);
        chk("badsum.err_const", 32'(load_err), 32'(1'b1));
        runFrame("frame_recover", 1'b0, 99, 8'h78);

        // Junk in IDLE is ignored.
        wrBase = wrLog.size();
        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h3C);
        idle(1);
        chk("junk.writes", 32'(wrLog.size() - wrBase), 32'd0);
        chkFlags("junk", expHold, expOk, expErr);
        for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
        runFrame("frame_after_junk", 1'b0, 99, refSum());

        // Timeout exactly TO cycles after the 5th data byte.
        for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
        wrBase = wrLog.size();
        sendByte(HDR);
        for (int i = 0; i < 5; i++) sendByte(fd[i]);
        idle(TO - 1);
        chk("timeout.early", 32'(load_err), 32'(1'b0));
        idle(1);
        modelFrame(5, 8'h00);
        checkFrame("timeout");
        sendByte(8'h11);
        chk("timeout.idle_nowrite", 32'(bus.wr_en), 32'(1'b0));

        // Byte arriving on the expiry cycle keeps the frame alive.
        for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
        wrBase = wrLog.size();
        sendByte(HDR);
        for (int i = 0; i < 5; i++) sendByte(fd[i]);
        idle(TO - 1);
        sendByte(fd[5]);
        chk("gap7.err",   32'(load_err),    32'(1'b0));
        chk("gap7.wren",  32'(bus.wr_en),   32'(1'b1));
        chk("gap7.waddr", 32'(bus.wr_addr), 32'd5);
        for (int i = 6; i < 16; i++) sendByte(fd[i]);
        sendByte(refSum());
        modelFrame(99, refSum());
        checkFrame("gap7");

        // Asynchronous reset mid-frame, then a full frame from address 0.
        for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
        sendByte(HDR);
        for (int i = 0; i < 3; i++) sendByte(fd[i]);
        #2;
        reset = 1'b0;
        #1;
        chkResetOutputs("midreset");
        #2;
        reset = 1'b1;
        tick();
        chk("midreset.ready", 32'(bus.in_ready), 32'(1'b1));
        for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
        runFrame("frame_after_reset", 1'b0, 99, refSum());

        // All-FF frame: checksum wraps to F0.
        for (int i = 0; i < 16; i++) fd[i] = 8'hFF;
        runFrame("frame_ff", 1'b0, 99, 8'hF0);
        chk("frame_ff.ok_const", 32'(load_ok), 32'(1'b1));

        // Randomized frames with gaps, junk, bad checksums and timeouts.
        for (int f = 0; f < 24; f++) begin
            nJunk = int'($urandom_range(2, 0));
            wrBase = wrLog.size();
            for (int j = 0; j < nJunk; j++) begin
                junk = 8'($urandom);
                if (junk == HDR) junk = 8'h00;
                sendByte(junk);
                idle(int'($urandom_range(2, 0)));
            end
            idle(1);
            chk($sformatf("rnd%0d.junk_writes", f), 32'(wrLog.size() - wrBase), 32'd0);
            for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
            abortAt = ($urandom_range(4, 0) == 0) ? int'($urandom_range(16, 0)) : 99;
            csum = ($urandom_range(1, 0) == 0) ? refSum() : 8'($urandom);
            runFrame($sformatf("rnd%0d", f), 1'b1, abortAt, csum);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
